// File: rtl/forward_propper_1.sv
// Forward-pass neuron: serially accumulates p*w products onto a bias, then presents
// the pre-activation sum, its ReLU activation and the gate flag used by the backward pass.
module forward_propper_1 #(
    parameter int unsigned N_INPUTS = 4,
    localparam int unsigned CNT_W = $clog2(N_INPUTS + 1)
) (
    input  logic        fp1_clk,
    input  logic        fp1_rst,
    input  logic        fp1_start,
    input  logic [31:0] fp1_bias,
    input  logic        fp1_in_valid,
    output logic        fp1_in_ready,
    input  logic [31:0] fp1_p,
    input  logic [31:0] fp1_w,
    output logic        fp1_out_valid,
    input  logic        fp1_out_ready,
    output logic [31:0] fp1_z,
    output logic [31:0] fp1_a,
    output logic        fp1_active,
    output logic        fp1_busy
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    localparam logic [CNT_W-1:0] LastBeat = CNT_W'(N_INPUTS - 1);

    state_e           state_q;
    logic [31:0]      acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      prod;

    // The low 32 bits of a two's-complement product do not depend on signedness.
    assign prod = fp1_p * fp1_w;

    always_ff @(posedge fp1_clk or posedge fp1_rst) begin
        if (fp1_rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fp1_start) begin
                        acc_q   <= fp1_bias;
                        cnt_q   <= '0;
                        state_q <= StAccum;
                    end
                end
                StAccum: begin
                    if (fp1_in_valid) begin
                        acc_q <= acc_q + prod;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LastBeat) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (fp1_out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Result outputs are gated to zero outside DONE so a partial sum never leaks.
    always_comb begin
        fp1_in_ready  = (state_q == StAccum);
        fp1_out_valid = (state_q == StDone);
        fp1_busy      = (state_q != StIdle);
        fp1_z         = '0;
        fp1_a         = '0;
        fp1_active    = 1'b0;
        if (state_q == StDone) begin
            fp1_z      = acc_q;
            fp1_a      = acc_q[31] ? 32'd0 : acc_q;
            fp1_active = ~acc_q[31];
        end
    end

endmodule

// File: tb/tb_forward_propper_1.sv
// Self-checking bench for forward_propper_1: a model computes each expected result into a
// scoreboard queue when an evaluation is launched; tests pop and compare on out_valid.
module tb_forward_propper_1;

    localparam int N = 4;

    typedef struct packed {
        logic [31:0] z;
        logic [31:0] a;
        logic        active;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] bias;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] p;
    logic [31:0] w;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;
    logic [31:0] a;
    logic        active;
    logic        busy;

    res_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    forward_propper_1 #(.N_INPUTS(N)) dut (
        .fp1_clk       (clk),
        .fp1_rst       (rst),
        .fp1_start     (start),
        .fp1_bias      (bias),
        .fp1_in_valid  (in_valid),
        .fp1_in_ready  (in_ready),
        .fp1_p         (p),
        .fp1_w         (w),
        .fp1_out_valid (out_valid),
        .fp1_out_ready (out_ready),
        .fp1_z         (z),
        .fp1_a         (a),
        .fp1_active    (active),
        .fp1_busy      (busy)
    );

    // Launches one evaluation and pushes the model's result. With gaps set, a stall cycle
    // carrying junk p/w and a start pulse precedes every beat.
    task automatic run_eval(input logic [31:0] b, input logic [N-1:0][31:0] pv,
                            input logic [N-1:0][31:0] wv, input bit gaps,
                            output int rdy_miss);
        logic [31:0]        acc;
        logic signed [63:0] full;
        res_t               r;
        acc = b;
        for (int i = 0; i < N; i++) begin
            full = $signed(pv[i]) * $signed(wv[i]);
            acc  = acc + full[31:0];
        end
        r.z      = acc;
        r.a      = acc[31] ? 32'd0 : acc;
        r.active = ~acc[31];
        sb.push_back(r);
        rdy_miss = 0;
        @(posedge clk); #1;
        start = 1'b1;
        bias  = b;
        @(posedge clk); #1;
        start = 1'b0;
        bias  = 32'hDEAD_BEEF;
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                p        = 32'h0000_1234;
                w        = 32'h0000_5678;
                start    = 1'b1;
                bias     = 32'h0000_0100;
                @(posedge clk); #1;
                start = 1'b0;
            end
            in_valid = 1'b1;
            p        = pv[i];
            w        = wv[i];
            @(negedge clk);
            if (in_ready !== 1'b1) rdy_miss++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        p        = '0;
        w        = '0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b1;
        bias      = 32'h0000_0055;
        in_valid  = 1'b1;
        p         = 32'd3;
        w         = 32'd3;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, z, a, active, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b z=%h a=%h act=%b busy=%b, need all 0",
                     in_ready, out_valid, z, a, active, busy);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b, need 0", busy);
        end
    endtask

    task automatic test_basic();
        int   miss;
        res_t exp_r;
        out_ready = 1'b1;
        run_eval(32'd1, {32'd5, 32'd4, 32'd3, 32'd2}, {32'd1, 32'd1, 32'd1, 32'd1}, 1'b0, miss);
        n_checks++;
        if (miss != 0) begin
            n_fail++;
            $display("FAIL basic_in_ready: %0d beats saw in_ready low, need 0", miss);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL basic_latency: ov/rdy/busy=%b%b%b, need 101", out_valid, in_ready, busy);
        end
        exp_r = sb.pop_front();
        n_checks++;
        if ({z, a, active} !== exp_r) begin
            n_fail++;
            $display("FAIL basic_result: got z=%h a=%h act=%b, need z=%h a=%h act=%b",
                     z, a, active, exp_r.z, exp_r.a, exp_r.active);
        end
        n_checks++;
        if (z !== 32'd15) begin
            n_fail++;
            $display("FAIL basic_z15: got z=%0d, need 15", z);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, busy, z, a, active} !== '0) begin
            n_fail++;
            $display("FAIL basic_pulse: ov=%b busy=%b z=%h a=%h act=%b, need all 0",
                     out_valid, busy, z, a, active);
        end
    endtask

    task automatic test_arith();
        logic [2:0][31:0]       biases;
        logic [2:0][N-1:0][31:0] pt;
        logic [2:0][N-1:0][31:0] wt;
        int   miss;
        res_t exp_r;
        biases[0] = 32'd0;
        pt[0]     = {32'd1, 32'd1, 32'd1, 32'd1};
        wt[0]     = {32'd0, 32'd0, 32'd1, 32'hFFFF_FFFD};
        biases[1] = 32'hFFFF_FFFC;
        pt[1]     = {32'd1, 32'd1, 32'd1, 32'd1};
        wt[1]     = {32'd1, 32'd1, 32'd1, 32'd1};
        biases[2] = 32'd7;
        pt[2]     = {32'd0, 32'd0, 32'd0, 32'h0001_0000};
        wt[2]     = {32'd0, 32'd0, 32'd0, 32'h0001_0000};
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            run_eval(biases[t], pt[t], wt[t], 1'b0, miss);
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL arith%0d_valid: out_valid=%b, need 1", t, out_valid);
            end
            exp_r = sb.pop_front();
            n_checks++;
            if ({z, a, active} !== exp_r) begin
                n_fail++;
                $display("FAIL arith%0d_result: got z=%h a=%h act=%b, need z=%h a=%h act=%b",
                         t, z, a, active, exp_r.z, exp_r.a, exp_r.active);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int   miss;
        res_t exp_r;
        out_ready = 1'b0;
        run_eval(32'hFFFF_FFF6, {32'd5, 32'd4, 32'd3, 32'd2}, {32'd1, 32'd1, 32'd1, 32'd1},
                 1'b1, miss);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_valid: out_valid=%b, need 1", out_valid);
        end
        exp_r = sb.pop_front();
        n_checks++;
        if ({z, a, active} !== exp_r) begin
            n_fail++;
            $display("FAIL bp_result: got z=%h a=%h act=%b, need z=%h a=%h act=%b",
                     z, a, active, exp_r.z, exp_r.a, exp_r.active);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            start = 1'b1;
            bias  = 32'h0000_0777;
            @(negedge clk);
            n_checks++;
            if ({out_valid, z, a, active} !== {1'b1, exp_r}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: ov=%b z=%h a=%h act=%b, need 1 z=%h a=%h act=%b",
                         k, out_valid, z, a, active, exp_r.z, exp_r.a, exp_r.active);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_handoff_start: ov=%b busy=%b, need 00", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        int   miss;
        res_t exp_r;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        bias  = 32'd100;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        p        = 32'd9;
        w        = 32'd9;
        repeat (2) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, z, a, active, busy} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: rdy=%b ov=%b z=%h a=%h act=%b busy=%b, need all 0",
                     in_ready, out_valid, z, a, active, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_eval(32'd1, {32'd5, 32'd4, 32'd3, 32'd2}, {32'd1, 32'd1, 32'd1, 32'd1}, 1'b0, miss);
        @(negedge clk);
        exp_r = sb.pop_front();
        n_checks++;
        if ({out_valid, z, a, active} !== {1'b1, exp_r}) begin
            n_fail++;
            $display("FAIL midreset_rerun: ov=%b z=%h a=%h act=%b, need 1 z=%h a=%h act=%b",
                     out_valid, z, a, active, exp_r.z, exp_r.a, exp_r.active);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_backpressure();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, need 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/forward_propper_1.md
Name: forward_propper_1

Overview:
- Forward-pass counterpart of the neuron back-propagation block: serially accumulates the 32-bit signed products p_i*w_i over N_INPUTS beats onto a bias.
- Applies the ReLU gate and presents the activation plus the gate flag that the backward pass consumes, which is 1 - sign of the pre-activation sum.
- Sits between the input/weight stream of a layer and the next layer's input stream.
- Valid/ready handshake on both sides.

Parameters:
- N_INPUTS, 4, number of p/w beats per neuron evaluation. Legal range >= 1.
- CNT_W, $clog2(N_INPUTS+1), width of the internal beat counter. Derived; do not override.

Ports:
- fp1_clk  input  1  clock; all state updates on the rising edge.
- fp1_rst  input  1  reset, asynchronous, active-high.
- fp1_start  input  1  single-cycle request to begin an evaluation; sampled only in IDLE.
- fp1_bias  input  32  signed bias; captured on the accepted start.
- fp1_in_valid  input  1  p/w beat valid.
- fp1_in_ready  output  1  block can accept a p/w beat.
- fp1_p  input  32  signed input value.
- fp1_w  input  32  signed weight.
- fp1_out_valid  output  1  result valid.
- fp1_out_ready  input  1  downstream accepts the result.
- fp1_z  output  32  signed pre-activation sum.
- fp1_a  output  32  activation (ReLU of fp1_z).
- fp1_active  output  1  ReLU gate, equal to ~fp1_z[31].
- fp1_busy  output  1  high in ACCUM or DONE.

Behaviour:
- States: IDLE, ACCUM, DONE.
- Reset (asynchronous, any state): state = IDLE, accumulator = 0, counter = 0. All outputs are 0: in_ready, out_valid, z, a, active, busy.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - On fp1_start = 1: acc <= fp1_bias, cnt <= 0, go to ACCUM.
- ACCUM:
  - in_ready = 1, busy = 1.
  - A beat is accepted when in_valid & in_ready. On acceptance: acc <= acc + low32(signed(p)*signed(w)), cnt <= cnt + 1.
  - After the N_INPUTS-th accepted beat, go to DONE on the same edge.
  - in_valid low stalls with no change to acc or cnt.
  - fp1_start is ignored in this state.
- DONE:
  - out_valid = 1, in_ready = 0. z = acc, a = (acc[31] ? 0 : acc), active = ~acc[31].
  - Outputs hold stable while out_ready = 0.
  - On out_valid & out_ready, go to IDLE.
  - fp1_start is ignored in DONE, including in the handoff cycle. A new start is honoured only in IDLE, so the earliest new start is one cycle after the result handoff.
- Outputs outside DONE: z, a and active are 0. The accumulator must not leak.
- Arithmetic:
  - Product is the low 32 bits of the 64-bit signed product.
  - Sum wraps modulo 2^32. No saturation, no overflow flag.
  - z = 0 gives active = 1 and a = 0. This matches the backward gate (1 - bit31).
- Latency: the result is valid on the cycle after the edge that accepts the last beat. Minimum start-to-out_valid is N_INPUTS+1 edges with in_valid held high.
- Timing: in_ready and out_valid are pure functions of state; no combinational path from in_valid or out_ready.
- Arithmetic can be done with one multiplier_1 instance or an inline signed multiply. Result must be bit-identical.

Test Plan:
- Basic sum: N=4, bias=1, p=(2,3,4,5), w=(1,1,1,1), in_valid held high, out_ready=1 -> out_valid 5 edges after start; z=15, a=15, active=1; one-cycle pulse, then IDLE.
- Negative gate: bias=0, p=(1,1,1,1), w=(-3,1,0,0) -> z=32'hFFFFFFFE, a=0, active=0.
- Zero sum: bias=-4, p=(1,1,1,1), w=(1,1,1,1) -> z=0, a=0, active=1.
- Wrap: bias=7, p=(32'h00010000,0,0,0), w=(32'h00010000,0,0,0) -> product truncates to 0; z=7, a=7.
- Backpressure and ignored start:
  - in_valid toggles 1,0,1,0,...; only high cycles count. out_valid appears 1 cycle after the 4th accepted beat.
  - out_ready held 0 for 3 cycles: z, a and active stay stable.
  - fp1_start pulsed during ACCUM and DONE changes nothing.
- Reset mid-operation:
  - Assert fp1_rst asynchronously after 2 accepted beats -> all outputs 0 immediately, state IDLE.
  - Then start with bias=1 and the basic-sum beats -> z=15, with no residue from the aborted run.
